// File: rtl/cond_pkg.sv
// Shared types for the condition unit: ARM condition codes, NZCV bit positions
// and the MUL sequencing states.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ, NE, CS, CC, MI, PL, VS, VC,
    HI, LS, GE, LT, GT, LE, AL, NV
  } cond_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic {IDLE, MUL_BUSY} cu_state_e;

endpackage

// File: rtl/cond_check.sv
// Purely combinational ARM condition evaluation of cond against {N,Z,C,V}.
// Zero latency, no flow control; also reused by the branch predictor.
module cond_check
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       pass
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      EQ: pass = z;
      NE: pass = !z;
      CS: pass = c;
      CC: pass = !c;
      MI: pass = n;
      PL: pass = !n;
      VS: pass = v;
      VC: pass = !v;
      HI: pass = c & !z;
      LS: pass = !c | z;
      GE: pass = (n == v);
      LT: pass = (n != v);
      GT: pass = !z & (n == v);
      LE: pass = z | (n != v);
      AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit.sv
// Flag register, condition gating of decoder write requests, and MUL sequencing.
// Enables are combinational in IDLE; a passing MUL stalls fetch for MUL_LAT-1 cycles.
module cond_unit
  import cond_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       InstrValid,
  input  logic [3:0] Cond,
  input  logic [3:0] ALUFlags,
  input  logic [1:0] FlagW,
  input  logic       PCS,
  input  logic       RegW,
  input  logic       MemW,
  input  logic       NoWrite,
  input  logic       MulStart,
  output logic       PCSrc,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       CondEx,
  output logic [3:0] Flags,
  output logic       Stall
);

  localparam logic       MUL_MULTI = (MUL_LAT > 1);
  localparam logic [3:0] CNT_LOAD  = (MUL_LAT > 1) ? 4'(MUL_LAT - 2) : 4'd0;

  cu_state_e  state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] flags_q;
  logic       lat_condex;
  logic       lat_regw;
  logic [1:0] lat_flagw;

  logic cond_pass, cond_ok, mul_go, commit;
  logic upd_nz, upd_cv;

  cond_check u_cond_check (
    .cond  (Cond),
    .flags (flags_q),
    .pass  (cond_pass)
  );

  assign cond_ok = InstrValid & cond_pass;
  assign mul_go  = (state == IDLE) & cond_ok & MulStart & MUL_MULTI;
  assign commit  = (state == MUL_BUSY) & (cnt == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (mul_go) state_nxt = MUL_BUSY;
      MUL_BUSY: if (cnt == 4'd0) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Everything is held low while reset is asserted, including a MUL in flight.
  always_comb begin
    CondEx   = 1'b0;
    Stall    = 1'b0;
    PCSrc    = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    upd_nz   = 1'b0;
    upd_cv   = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          CondEx   = cond_ok;
          Stall    = mul_go;
          PCSrc    = PCS & cond_ok & !MulStart;
          MemWrite = MemW & cond_ok & !MulStart;
          RegWrite = RegW & cond_ok & !NoWrite & !mul_go;
          upd_nz   = cond_ok & FlagW[1] & !mul_go;
          upd_cv   = cond_ok & FlagW[0] & !mul_go;
        end
        MUL_BUSY: begin
          CondEx   = lat_condex;
          Stall    = (cnt != 4'd0);
          RegWrite = commit & lat_regw;
          upd_nz   = commit & lat_flagw[1];
          upd_cv   = commit & lat_flagw[0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q    <= 4'b0000;
      cnt        <= 4'd0;
      lat_condex <= 1'b0;
      lat_regw   <= 1'b0;
      lat_flagw  <= 2'b00;
    end else begin
      if (upd_nz) flags_q[FLAG_N:FLAG_Z] <= ALUFlags[FLAG_N:FLAG_Z];
      if (upd_cv) flags_q[FLAG_C:FLAG_V] <= ALUFlags[FLAG_C:FLAG_V];
      if (mul_go) begin
        cnt        <= CNT_LOAD;
        lat_condex <= cond_ok;
        lat_regw   <= RegW;
        lat_flagw  <= FlagW;
      end else if ((state == MUL_BUSY) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  assign Flags = reset ? 4'b0000 : flags_q;

endmodule

// File: tb/tb_cond_unit.sv
// Bench for cond_unit: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a cycle-occupancy model.
module tb_cond_unit;

  localparam int MUL_LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       iv;
  logic [3:0] cond;
  logic [3:0] aluf;
  logic [1:0] flagw;
  logic       pcs, regw, memw, nowr, mul;

  logic       PCSrc, RegWrite, MemWrite, CondEx, Stall;
  logic [3:0] Flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cond_unit #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset      (rst),
    .InstrValid (iv),
    .Cond       (cond),
    .ALUFlags   (aluf),
    .FlagW      (flagw),
    .PCS        (pcs),
    .RegW       (regw),
    .MemW       (memw),
    .NoWrite    (nowr),
    .MulStart   (mul),
    .PCSrc      (PCSrc),
    .RegWrite   (RegWrite),
    .MemWrite   (MemWrite),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .Stall      (Stall)
  );

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, expv, $time);
    end
  endtask

  // Classic ARM form: cond[3:1] picks a base test, cond[0] inverts it.
  function automatic logic model_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return base ^ c[0];
  endfunction

  // Model: architectural flags plus the number of MUL cycles still to run after this one.
  logic [3:0] m_flags = 4'b0000;
  int         m_left  = 0;
  logic       m_regw  = 1'b0;
  logic [1:0] m_flagw = 2'b00;

  logic       e_condex, e_stall, e_pcsrc, e_regwrite, e_memwrite, pass;
  logic [3:0] e_flags, nf;

  always @(negedge clk) begin
    e_condex = 0; e_stall = 0; e_pcsrc = 0; e_regwrite = 0; e_memwrite = 0;
    e_flags = rst ? 4'b0000 : m_flags;
    nf = m_flags;
    if (rst) begin
      nf = 4'b0000;
      m_left = 0;
    end else if (m_left > 0) begin
      e_condex = 1'b1;
      if (m_left > 1) begin
        e_stall = 1'b1;
      end else begin
        e_regwrite = m_regw;
        if (m_flagw[1]) nf[3:2] = aluf[3:2];
        if (m_flagw[0]) nf[1:0] = aluf[1:0];
      end
      m_left = m_left - 1;
    end else begin
      pass = iv && model_cond(cond, m_flags);
      e_condex = pass;
      if (pass && mul && MUL_LAT > 1) begin
        e_stall = 1'b1;
        m_left  = MUL_LAT - 1;
        m_regw  = regw;
        m_flagw = flagw;
      end else begin
        e_pcsrc    = pcs && pass && !mul;
        e_memwrite = memw && pass && !mul;
        e_regwrite = regw && pass && !nowr;
        if (pass && flagw[1]) nf[3:2] = aluf[3:2];
        if (pass && flagw[0]) nf[1:0] = aluf[1:0];
      end
    end
    chk("cyc_condex",   {3'b0, CondEx},   {3'b0, e_condex});
    chk("cyc_stall",    {3'b0, Stall},    {3'b0, e_stall});
    chk("cyc_pcsrc",    {3'b0, PCSrc},    {3'b0, e_pcsrc});
    chk("cyc_regwrite", {3'b0, RegWrite}, {3'b0, e_regwrite});
    chk("cyc_memwrite", {3'b0, MemWrite}, {3'b0, e_memwrite});
    chk("cyc_flags",    Flags,            e_flags);
    m_flags = nf;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iv = 0; cond = 4'hE; aluf = 4'h0; flagw = 2'b00;
    pcs = 0; regw = 0; memw = 0; nowr = 0; mul = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    repeat (2) cyc();
    rst = 1'b0;
    iv = 1; cond = 4'hE; flagw = 2'b11; aluf = 4'hF;
    cyc();
    idle_in();
    #1 chk("flags_preload", Flags, 4'hF);

    rst = 1'b1;
    #1 chk("rst_cycle_stall", {3'b0, Stall}, 4'd0);
    chk("rst_cycle_flags", Flags, 4'h0);
    cyc();
    rst = 1'b0;
    #1 chk("rst_flags", Flags, 4'h0);
    chk("rst_enables", {1'b0, PCSrc, RegWrite, MemWrite}, 4'd0);
    chk("rst_stall", {3'b0, Stall}, 4'd0);

    iv = 1; cond = 4'hE; flagw = 2'b11; aluf = 4'b0100;
    cyc();
    idle_in(); iv = 1; cond = 4'h0; regw = 1;
    #1 chk("z_loaded", Flags, 4'b0100);
    chk("eq_regwrite", {3'b0, RegWrite}, 4'd1);
    cyc();
    cond = 4'h1;
    #1 chk("ne_regwrite", {3'b0, RegWrite}, 4'd0);

    cyc();
    cond = 4'hE; nowr = 1; regw = 1; flagw = 2'b11; aluf = 4'b1000;
    #1 chk("cmp_regwrite", {3'b0, RegWrite}, 4'd0);
    cyc();
    idle_in(); iv = 1; cond = 4'hB;
    #1 chk("cmp_flags", Flags, 4'b1000);
    chk("lt_condex", {3'b0, CondEx}, 4'd1);
    cyc();
    cond = 4'hA;
    #1 chk("ge_condex", {3'b0, CondEx}, 4'd0);

    cyc();
    cond = 4'h0; flagw = 2'b11; memw = 1; pcs = 1; aluf = 4'b0111;
    #1 chk("fail_memwrite", {3'b0, MemWrite}, 4'd0);
    chk("fail_pcsrc", {3'b0, PCSrc}, 4'd0);
    cyc();
    idle_in();
    #1 chk("fail_flags", Flags, 4'b1000);

    iv = 1; cond = 4'hE; regw = 1; flagw = 2'b10; mul = 1; aluf = 4'b0111;
    #1 chk("mul_c1_stall", {3'b0, Stall}, 4'd1);
    chk("mul_c1_regwrite", {3'b0, RegWrite}, 4'd0);
    cyc();
    #1 chk("mul_c2_stall", {3'b0, Stall}, 4'd1);
    chk("mul_c2_regwrite", {3'b0, RegWrite}, 4'd0);
    cyc();
    #1 chk("mul_c3_stall", {3'b0, Stall}, 4'd0);
    chk("mul_c3_regwrite", {3'b0, RegWrite}, 4'd1);
    cyc();
    idle_in();
    #1 chk("mul_flags", Flags, 4'b0100);

    iv = 1; cond = 4'hE; regw = 1; flagw = 2'b11; mul = 1; aluf = 4'hF;
    cyc();
    rst = 1'b1;
    #1 chk("mulrst_c2_stall", {3'b0, Stall}, 4'd0);
    cyc();
    rst = 1'b0;
    idle_in();
    #1 chk("mulrst_c3_stall", {3'b0, Stall}, 4'd0);
    chk("mulrst_c3_regwrite", {3'b0, RegWrite}, 4'd0);
    chk("mulrst_c3_flags", Flags, 4'h0);
    iv = 1; cond = 4'hE; regw = 1;
    #1 chk("mulrst_idle_regwrite", {3'b0, RegWrite}, 4'd1);

    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst   = ($urandom_range(0, 63) == 0);
      iv    = ($urandom_range(0, 7) != 0);
      cond  = 4'($urandom_range(0, 15));
      aluf  = 4'($urandom_range(0, 15));
      flagw = 2'($urandom_range(0, 3));
      pcs   = 1'($urandom_range(0, 1));
      regw  = 1'($urandom_range(0, 1));
      memw  = 1'($urandom_range(0, 1));
      nowr  = 1'($urandom_range(0, 1));
      mul   = ($urandom_range(0, 4) == 0);
      if (mul && $urandom_range(0, 3) != 0) begin
        pcs = 0; memw = 0; nowr = 0;
      end
    end
    cyc();
    rst = 1'b0;
    idle_in();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
